// File: rtl/bnn_estimate_pkg.sv
// Shared types and arithmetic helpers for the binarized estimate array.
// Contents: com_e command encoding, most-negative/most-positive constants
// for a signed width, and a saturating add used when ACC_SAT_EN is defined.
package bnn_estimate_pkg;

  localparam int unsigned COM_W  = 3;
  localparam int unsigned CALC_W = 64;

  typedef enum logic [COM_W-1:0] {
    INI   = 3'd0,
    ACC   = 3'd1,
    POOL  = 3'd2,
    NORM  = 3'd3,
    ACTIV = 3'd4
  } com_e;

  // Most negative value of a w-bit signed number, sign-extended to CALC_W.
  function automatic logic signed [CALC_W-1:0] most_neg(input int unsigned w);
    return -(64'sd1 <<< (w - 1));
  endfunction

  // Most positive value of a w-bit signed number.
  function automatic logic signed [CALC_W-1:0] max_pos(input int unsigned w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  // a + b clamped to the signed w-bit range (operands must not overflow CALC_W).
  function automatic logic signed [CALC_W-1:0] sat_add(input logic signed [CALC_W-1:0] a,
                                                       input logic signed [CALC_W-1:0] b,
                                                       input int unsigned w);
    logic signed [CALC_W-1:0] s;
    logic signed [CALC_W-1:0] hi;
    logic signed [CALC_W-1:0] lo;
    s  = a + b;
    hi = max_pos(w);
    lo = most_neg(w);
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

endpackage

// File: rtl/bnn_estimate_array_popcount.sv
// bnn_popcount: combinational population count of a WIDTH-bit word.
// Ports: bits (in, WIDTH), count (out, $clog2(WIDTH)+1).
module bnn_popcount #(
  parameter  int unsigned WIDTH = 32,
  localparam int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic [WIDTH-1:0] bits,
  output logic [CNT_W-1:0] count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < WIDTH; i++) begin
      count = count + CNT_W'(bits[i]);
    end
  end

endmodule

// File: rtl/bnn_estimate_array.sv
// bnn_estimate_array: NCH lock-step binarized estimate channels
// (XNOR-popcount accumulate, max-pool, normalize, sign activation).
// Optional macro ACC_SAT_EN: saturate ACC add and NORM shift/subtract
// instead of wrapping modulo 2^ACC_W.
// Ports: clk, reset (async, active-high); in_valid/com/addr/data command
// stream; p_addr (comb. = addr) / p_rdata (1-cycle latency, NCH lanes)
// parameter RAM; activ (per-channel pool sign) with activ_valid pulse.
module bnn_estimate_array
  import bnn_estimate_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned NCH        = 4,
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned ACC_W      = 16,
  parameter int unsigned NORM_SHIFT = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [COM_W-1:0]       com,
  input  logic [ADDR_W-1:0]      addr,
  input  logic [WIDTH-1:0]       data,
  output logic [ADDR_W-1:0]      p_addr,
  input  logic [NCH*WIDTH-1:0]   p_rdata,
  output logic [NCH-1:0]         activ,
  output logic                   activ_valid
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
  localparam logic signed [ACC_W-1:0] POOL_RST = ACC_W'(most_neg(ACC_W));

  // acc + 2*popcount, wrapping or saturating.
  function automatic logic signed [ACC_W-1:0] acc_add(input logic signed [ACC_W-1:0] a,
                                                      input logic [CNT_W-1:0] n);
`ifdef ACC_SAT_EN
    return ACC_W'(sat_add(CALC_W'(a), CALC_W'({n, 1'b0}), ACC_W));
`else
    return a + ACC_W'({n, 1'b0});
`endif
  endfunction

  // (pool << NORM_SHIFT) - threshold, wrapping or saturating.
  function automatic logic signed [ACC_W-1:0] norm(input logic signed [ACC_W-1:0] p,
                                                   input logic signed [ACC_W-1:0] t);
`ifdef ACC_SAT_EN
    return ACC_W'(sat_add(CALC_W'(p) <<< NORM_SHIFT, -CALC_W'(t), ACC_W));
`else
    return ACC_W'(p <<< NORM_SHIFT) - t;
`endif
  endfunction

  logic                   s0_valid, s1_valid, s2_valid;
  logic [COM_W-1:0]       s0_com, s1_com, s2_com;
  logic [WIDTH-1:0]       s0_data, s1_data;
  logic [NCH*WIDTH-1:0]   s1_lane;
  logic [WIDTH-1:0]       s2_opnd [NCH];
  logic [CNT_W-1:0]       pcnt    [NCH];
  logic signed [ACC_W-1:0] acc_q  [NCH];
  logic signed [ACC_W-1:0] pool_q [NCH];
  logic signed [ACC_W-1:0] acc_d  [NCH];
  logic signed [ACC_W-1:0] pool_d [NCH];

  // RAM sees addr in the accept cycle, so its data lines up with S1.
  assign p_addr = addr;

  // S0 accept and S1 capture (command plus RAM lanes).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s0_valid <= 1'b0;
      s0_com   <= '0;
      s0_data  <= '0;
      s1_valid <= 1'b0;
      s1_com   <= '0;
      s1_data  <= '0;
      s1_lane  <= '0;
    end else begin
      s0_valid <= in_valid;
      s0_com   <= com;
      s0_data  <= data;
      s1_valid <= s0_valid;
      s1_com   <= s0_com;
      s1_data  <= s0_data;
      s1_lane  <= p_rdata;
    end
  end

  // S2 per-channel operand select; unused commands hold the old operand.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_com   <= '0;
      for (int c = 0; c < NCH; c++) s2_opnd[c] <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_com   <= s1_com;
      for (int c = 0; c < NCH; c++) begin
        if (s1_valid) begin
          case (com_e'(s1_com))
            INI, POOL: s2_opnd[c] <= s1_data;
            ACC:       s2_opnd[c] <= ~(s1_data ^ s1_lane[c*WIDTH +: WIDTH]);
            NORM:      s2_opnd[c] <= s1_lane[c*WIDTH +: WIDTH];
            default:   ;
          endcase
        end
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_pc
    bnn_popcount #(.WIDTH(WIDTH)) u_popcount (
      .bits  (s2_opnd[g]),
      .count (pcnt[g])
    );
  end

  // S3 next-state: acc/pool only ever read and written here, so no hazards.
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      acc_d[c]  = acc_q[c];
      pool_d[c] = pool_q[c];
      if (s2_valid) begin
        case (com_e'(s2_com))
          INI: begin
            acc_d[c]  = s2_opnd[c][ACC_W-1:0];
            pool_d[c] = POOL_RST;
          end
          ACC: acc_d[c] = acc_add(acc_q[c], pcnt[c]);
          POOL: begin
            if (acc_q[c] > pool_q[c]) pool_d[c] = acc_q[c];
            acc_d[c] = s2_opnd[c][ACC_W-1:0];
          end
          NORM:    pool_d[c] = norm(pool_q[c], s2_opnd[c][ACC_W-1:0]);
          default: ;
        endcase
      end
    end
  end

  // S3 channel state and activation output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NCH; c++) begin
        acc_q[c]  <= '0;
        pool_q[c] <= POOL_RST;
      end
      activ       <= '0;
      activ_valid <= 1'b0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        acc_q[c]  <= acc_d[c];
        pool_q[c] <= pool_d[c];
        if (s2_valid && (s2_com == ACTIV)) activ[c] <= pool_q[c][ACC_W-1];
      end
      activ_valid <= s2_valid && (s2_com == ACTIV);
    end
  end

endmodule

// File: tb/tb_bnn_estimate_array.sv
module tb_bnn_estimate_array;

  localparam int unsigned WIDTH      = 32;
  localparam int unsigned NCH        = 4;
  localparam int unsigned ADDR_W     = 16;
  localparam int unsigned ACC_W      = 16;
  localparam int unsigned NORM_SHIFT = 6;

  localparam logic [2:0] C_INI = 3'd0, C_ACC = 3'd1, C_POOL = 3'd2, C_NORM = 3'd3, C_ACTIV = 3'd4;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  in_valid = 1'b0;
  logic [2:0]            com = '0;
  logic [ADDR_W-1:0]     addr = '0;
  logic [WIDTH-1:0]      data = '0;
  logic [ADDR_W-1:0]     p_addr;
  logic [NCH*WIDTH-1:0]  p_rdata;
  logic [NCH-1:0]        activ;
  logic                  activ_valid;

  logic [NCH*WIDTH-1:0]  ram [16];

  typedef struct {
    logic [NCH-1:0] activ;
    int             due;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   acc_m  [NCH];
  int   pool_m [NCH];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  bnn_estimate_array #(
    .WIDTH(WIDTH), .NCH(NCH), .ADDR_W(ADDR_W), .ACC_W(ACC_W), .NORM_SHIFT(NORM_SHIFT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .com         (com),
    .addr        (addr),
    .data        (data),
    .p_addr      (p_addr),
    .p_rdata     (p_rdata),
    .activ       (activ),
    .activ_valid (activ_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) p_rdata <= ram[p_addr[3:0]];

  initial begin
    #300000;
    $display("FAIL watchdog timeout at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  function automatic int lo16(input int x);
    logic signed [15:0] t;
    t = 16'(x);
    return int'(t);
  endfunction

  function automatic int fit(input int x);
`ifdef ACC_SAT_EN
    if (x > 32767) return 32767;
    if (x < -32768) return -32768;
    return x;
`else
    return lo16(x);
`endif
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      acc_m[c]  = 0;
      pool_m[c] = -32768;
    end
    exp_q.delete();
  endtask

  // Drive one input cycle now and advance the reference model.
  task automatic drive(input logic v, input logic [2:0] c, input logic [15:0] a, input logic [31:0] d);
    exp_t e;
    logic [31:0] lane;
    in_valid = v; com = c; addr = a; data = d;
    if (v) begin
      e.activ = '0;
      e.due   = cyc + 4;
      for (int ch = 0; ch < NCH; ch++) begin
        lane = ram[a[3:0]][ch*WIDTH +: WIDTH];
        case (c)
          C_INI: begin acc_m[ch] = lo16(d); pool_m[ch] = -32768; end
          C_ACC: acc_m[ch] = fit(acc_m[ch] + 2 * $countones(~(d ^ lane)));
          C_POOL: begin
            if (acc_m[ch] > pool_m[ch]) pool_m[ch] = acc_m[ch];
            acc_m[ch] = lo16(d);
          end
          C_NORM:  pool_m[ch] = fit(pool_m[ch] * 64 - lo16(lane));
          C_ACTIV: e.activ[ch] = (pool_m[ch] < 0);
          default: ;
        endcase
      end
      if (c == C_ACTIV) exp_q.push_back(e);
    end
  endtask

  task automatic issue(input logic [2:0] c, input logic [15:0] a, input logic [31:0] d);
    @(negedge clk);
    drive(1'b1, c, a, d);
  endtask

  task automatic drain();
    @(negedge clk);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_activ_valid pending=%0d required=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Scoreboard: every activ_valid pulse must match the oldest expected ACTIV.
  always @(negedge clk) begin
    if (!reset && activ_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_activ_valid cyc=%0d activ=%b", cyc, activ);
      end else begin
        mon_e = exp_q.pop_front();
        if (activ !== mon_e.activ || cyc != mon_e.due) begin
          errors++;
          $display("FAIL activ got=%b at cyc %0d required=%b at cyc %0d", activ, cyc, mon_e.activ, mon_e.due);
        end
      end
    end
  end

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (activ !== 4'b0000) begin
      errors++; $display("FAIL reset_activ got=%b required=0000", activ);
    end
    checks++;
    if (activ_valid !== 1'b0) begin
      errors++; $display("FAIL reset_activ_valid got=%b required=0", activ_valid);
    end
    reset = 1'b0;
  endtask

  task automatic test_ini_activ();
    test_reset();
    issue(C_INI, 16'd0, 32'h0000_0005);
    issue(C_ACTIV, 16'd0, 32'h0);
    drain();
    checks++;
    if (activ !== 4'b1111) begin
      errors++; $display("FAIL ini_activ got=%b required=1111", activ);
    end
  endtask

  task automatic test_acc_pool();
    issue(C_INI, 16'd0, 32'h0);
    issue(C_ACC, 16'd1, 32'hFFFF_FFFF);
    issue(C_POOL, 16'd0, 32'h0);
    issue(C_ACTIV, 16'd0, 32'h0);
    drain();
    checks++;
    if (activ[1:0] !== 2'b00) begin
      errors++; $display("FAIL acc_pool got=%b required=00", activ[1:0]);
    end
  endtask

  task automatic test_pool_keep();
    issue(C_INI, 16'd0, 32'h0);
    issue(C_ACC, 16'd1, 32'hFFFF_FFFF);
    issue(C_POOL, 16'd0, 32'h0);
    issue(C_ACC, 16'd2, 32'hFFFF_FFE0);
    issue(C_POOL, 16'd0, 32'h0);
    issue(C_NORM, 16'd3, 32'h0);
    issue(C_ACTIV, 16'd0, 32'h0);
    drain();
    checks++;
    if (activ[0] !== 1'b0) begin
      errors++; $display("FAIL pool_keep got=%b required=0", activ[0]);
    end
  endtask

  task automatic test_norm();
    issue(C_INI, 16'd0, 32'h0000_0003);
    issue(C_POOL, 16'd0, 32'h0);
    issue(C_NORM, 16'd4, 32'h0);
    issue(C_ACTIV, 16'd0, 32'h0);
    drain();
    checks++;
    if (activ[0] !== 1'b1) begin
      errors++; $display("FAIL norm_neg got=%b required=1", activ[0]);
    end
  endtask

  task automatic test_sat();
    logic req;
`ifdef ACC_SAT_EN
    req = 1'b0;
`else
    req = 1'b1;
`endif
    issue(C_INI, 16'd0, 32'h0000_7FF0);
    issue(C_ACC, 16'd1, 32'hFFFF_FFFF);
    issue(C_POOL, 16'd0, 32'h0);
    issue(C_ACTIV, 16'd0, 32'h0);
    drain();
    checks++;
    if (activ[0] !== req) begin
      errors++; $display("FAIL acc_overflow got=%b required=%b", activ[0], req);
    end
  endtask

  task automatic test_reset_midflight();
    issue(C_INI, 16'd0, 32'h0000_0100);
    issue(C_ACC, 16'd1, 32'hFFFF_FFFF);
    issue(C_POOL, 16'd0, 32'h0);
    issue(C_ACTIV, 16'd0, 32'h0);
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (activ_valid !== 1'b0 || activ !== 4'b0000) begin
        errors++; $display("FAIL midflight_reset valid=%b activ=%b required 0/0000", activ_valid, activ);
      end
    end
    // First command goes in on the very edge after release.
    reset = 1'b0;
    drive(1'b1, C_ACTIV, 16'd0, 32'h0);
    issue(C_POOL, 16'd0, 32'h0);
    issue(C_ACTIV, 16'd0, 32'h0);
    drain();
    checks++;
    if (activ !== 4'b0000) begin
      errors++; $display("FAIL post_reset_acc got=%b required=0000", activ);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 8; i < 12; i++) ram[i] = {$urandom, $urandom, $urandom, $urandom};
    issue(C_INI, 16'd0, $urandom);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      drive($urandom_range(0, 9) < 8, 3'($urandom_range(0, 7)), 16'(8 + $urandom_range(0, 3)), $urandom);
    end
    issue(C_ACTIV, 16'd0, 32'h0);
    drain();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) ram[i] = '0;
    ram[1] = {32'h5555_5555, 32'h5555_5555, 32'h0000_0000, 32'hFFFF_FFFF};
    ram[2] = {32'h1234_5678, 32'hAAAA_0000, 32'hFFFF_0000, 32'h0000_0000};
    ram[3] = {32'h0000_0100, 32'h0000_8000, 32'h0000_7FFF, 32'h0000_03E8};
    ram[4] = {32'h0000_FF00, 32'h0000_0001, 32'h0000_0000, 32'h0000_00C8};
    model_reset();
    repeat (2) @(negedge clk);
    test_reset();
    test_ini_activ();
    test_acc_pool();
    test_pool_keep();
    test_norm();
    test_sat();
    test_reset_midflight();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
